// File: rtl/display_timing_pkg.sv
// Shared raster timing descriptions: one struct per axis, common CEA/DMT presets
// and a helper that sums an axis into its total period.
package display_timing_pkg;

  typedef struct packed {
    int   active;
    int   fp;
    int   sync;
    int   bp;
    logic pol;
  } timing_t;

  localparam timing_t T_640x480_H   = '{active: 640,  fp: 16,  sync: 96,  bp: 48,  pol: 1'b0};
  localparam timing_t T_640x480_V   = '{active: 480,  fp: 10,  sync: 2,   bp: 33,  pol: 1'b0};
  localparam timing_t T_800x600_H   = '{active: 800,  fp: 40,  sync: 128, bp: 88,  pol: 1'b1};
  localparam timing_t T_800x600_V   = '{active: 600,  fp: 1,   sync: 4,   bp: 23,  pol: 1'b1};
  localparam timing_t T_1280x720_H  = '{active: 1280, fp: 110, sync: 40,  bp: 220, pol: 1'b1};
  localparam timing_t T_1280x720_V  = '{active: 720,  fp: 5,   sync: 5,   bp: 20,  pol: 1'b1};

  function automatic int total(timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/display_timing_axis.sv
// One raster axis: position counter with increment/zero controls, end-of-axis flag,
// and sync/blank decode of the position the counter is about to take.
module display_timing_axis #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CORDW  = 12
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             inc,
  input  logic             zero,
  output logic [CORDW-1:0] pos,
  output logic             at_end,
  output logic             sync_next,
  output logic             blank_next
);

  localparam int               TOTAL    = ACTIVE + FP + SYNC + BP;
  localparam logic [CORDW-1:0] LAST     = CORDW'(TOTAL - 1);
  localparam logic [CORDW-1:0] ACT_END  = CORDW'(ACTIVE);
  localparam logic [CORDW-1:0] SYNC_ON  = CORDW'(ACTIVE + FP);
  localparam logic [CORDW-1:0] SYNC_OFF = CORDW'(ACTIVE + FP + SYNC);

  logic [CORDW-1:0] pos_next;

  assign at_end = (pos == LAST);

  // zero beats inc so a restart lands on 0 rather than pos+1
  always_comb begin
    pos_next = pos;
    if (zero) begin
      pos_next = '0;
    end else if (inc) begin
      pos_next = at_end ? '0 : pos + CORDW'(1);
    end
  end

  assign sync_next  = (pos_next >= SYNC_ON) && (pos_next < SYNC_OFF);
  assign blank_next = (pos_next >= ACT_END);

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      pos <= LAST;
    end else begin
      pos <= pos_next;
    end
  end

endmodule

// File: rtl/display_timings_gen.sv
// Parametrised raster timing generator: chains horizontal wrap into vertical
// increment, handles pixel enable and restart, and registers all outputs together.
module display_timings_gen
  import display_timing_pkg::*;
#(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   CORDW    = 12
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             ce,
  input  logic             restart,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             hblank,
  output logic             vblank,
  output logic             line,
  output logic             frame
);

  localparam timing_t H_T     = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP, pol: H_POL};
  localparam timing_t V_T     = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP, pol: V_POL};
  localparam int      H_TOTAL = total(H_T);
  localparam int      V_TOTAL = total(V_T);
  localparam int      CAP     = 2 ** CORDW;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
    $error("display_timings_gen: horizontal timing values must all be >= 1");
  end
  if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
    $error("display_timings_gen: vertical timing values must all be >= 1");
  end
  if (CAP < H_TOTAL || CAP < V_TOTAL) begin : g_bad_cordw
    $error("display_timings_gen: CORDW too narrow for H_TOTAL/V_TOTAL");
  end

  logic restart_pend;
  logic jump;
  logic h_end, v_end;
  logic h_sync_next, v_sync_next;
  logic h_blank_next, v_blank_next;

  assign jump = ce && (restart || restart_pend);

  display_timing_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CORDW(CORDW)
  ) u_h_axis (
    .clk_pix    (clk_pix),
    .rst        (rst),
    .inc        (ce),
    .zero       (jump),
    .pos        (sx),
    .at_end     (h_end),
    .sync_next  (h_sync_next),
    .blank_next (h_blank_next)
  );

  display_timing_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CORDW(CORDW)
  ) u_v_axis (
    .clk_pix    (clk_pix),
    .rst        (rst),
    .inc        (ce && h_end),
    .zero       (jump),
    .pos        (sy),
    .at_end     (v_end),
    .sync_next  (v_sync_next),
    .blank_next (v_blank_next)
  );

  // A restart seen without ce is remembered until the next enabled pixel consumes it
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      restart_pend <= 1'b0;
    end else if (ce) begin
      restart_pend <= 1'b0;
    end else if (restart) begin
      restart_pend <= 1'b1;
    end
  end

  // Decodes come from the next position, so outputs line up with sx/sy on the same edge
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      hsync  <= ~H_POL;
      vsync  <= ~V_POL;
      de     <= 1'b0;
      hblank <= 1'b1;
      vblank <= 1'b1;
      line   <= 1'b0;
      frame  <= 1'b0;
    end else if (ce) begin
      hsync  <= h_sync_next ? H_POL : ~H_POL;
      vsync  <= v_sync_next ? V_POL : ~V_POL;
      de     <= !h_blank_next && !v_blank_next;
      hblank <= h_blank_next;
      vblank <= v_blank_next;
      line   <= jump || h_end;
      frame  <= jump || (h_end && v_end);
    end
  end

endmodule

// File: tb/tb_display_timings_gen.sv
// Bench for display_timings_gen: three geometries driven in lockstep and compared
// every cycle against a linear-pixel-index model of the raster.
module tb_display_timings_gen;
  import display_timing_pkg::*;

  logic clk_pix;
  logic rst, ce, restart;

  logic [11:0] d_sx, d_sy;
  logic        d_hs, d_vs, d_de, d_hb, d_vb, d_ln, d_fr;
  logic [11:0] h_sx, h_sy;
  logic        h_hs, h_vs, h_de, h_hb, h_vb, h_ln, h_fr;
  logic [3:0]  t_sx, t_sy;
  logic        t_hs, t_vs, t_de, t_hb, t_vb, t_ln, t_fr;

  // mode 0 = 640x480 default, 1 = 1280x720, 2 = tiny 15x11 raster
  int h_act [3] = '{640, 1280, 8};
  int h_fp  [3] = '{16, 110, 2};
  int h_syn [3] = '{96, 40, 3};
  int h_bp  [3] = '{48, 220, 2};
  bit h_pol [3] = '{1'b0, 1'b1, 1'b1};
  int v_act [3] = '{480, 720, 6};
  int v_fp  [3] = '{10, 5, 1};
  int v_syn [3] = '{2, 5, 2};
  int v_bp  [3] = '{33, 20, 2};
  bit v_pol [3] = '{1'b0, 1'b1, 1'b0};

  int pos [3];
  bit pend;
  int vectors;
  int miscompares;
  int cycle;

  display_timings_gen u_dflt (
    .clk_pix(clk_pix), .rst(rst), .ce(ce), .restart(restart),
    .sx(d_sx), .sy(d_sy), .hsync(d_hs), .vsync(d_vs), .de(d_de),
    .hblank(d_hb), .vblank(d_vb), .line(d_ln), .frame(d_fr)
  );

  display_timings_gen #(
    .H_ACTIVE(T_1280x720_H.active), .H_FP(T_1280x720_H.fp),
    .H_SYNC(T_1280x720_H.sync), .H_BP(T_1280x720_H.bp),
    .V_ACTIVE(T_1280x720_V.active), .V_FP(T_1280x720_V.fp),
    .V_SYNC(T_1280x720_V.sync), .V_BP(T_1280x720_V.bp),
    .H_POL(T_1280x720_H.pol), .V_POL(T_1280x720_V.pol), .CORDW(12)
  ) u_hd (
    .clk_pix(clk_pix), .rst(rst), .ce(ce), .restart(restart),
    .sx(h_sx), .sy(h_sy), .hsync(h_hs), .vsync(h_vs), .de(h_de),
    .hblank(h_hb), .vblank(h_vb), .line(h_ln), .frame(h_fr)
  );

  display_timings_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b1), .V_POL(1'b0), .CORDW(4)
  ) u_tiny (
    .clk_pix(clk_pix), .rst(rst), .ce(ce), .restart(restart),
    .sx(t_sx), .sy(t_sy), .hsync(t_hs), .vsync(t_vs), .de(t_de),
    .hblank(t_hb), .vblank(t_vb), .line(t_ln), .frame(t_fr)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  function automatic int h_tot(int m);
    return h_act[m] + h_fp[m] + h_syn[m] + h_bp[m];
  endfunction

  function automatic int v_tot(int m);
    return v_act[m] + v_fp[m] + v_syn[m] + v_bp[m];
  endfunction

  function automatic logic [31:0] pack(int x, int y, logic hs, logic vs, logic de,
                                       logic hb, logic vb, logic ln, logic fr);
    logic [11:0] xs, ys;
    xs = x[11:0];
    ys = y[11:0];
    return {xs, ys, 1'b0, hs, vs, de, hb, vb, ln, fr};
  endfunction

  // Raster position is a single pixel index p; x/y and every flag follow from it
  function automatic logic [31:0] expect_vec(int m, int p);
    int  x, y;
    logic hs, vs;
    x  = p % h_tot(m);
    y  = p / h_tot(m);
    hs = (x >= h_act[m] + h_fp[m] && x < h_act[m] + h_fp[m] + h_syn[m]) ? h_pol[m] : !h_pol[m];
    vs = (y >= v_act[m] + v_fp[m] && y < v_act[m] + v_fp[m] + v_syn[m]) ? v_pol[m] : !v_pol[m];
    return pack(x, y, hs, vs, (x < h_act[m]) && (y < v_act[m]),
                x >= h_act[m], y >= v_act[m], x == 0, p == 0);
  endfunction

  task automatic model_step(bit r, bit c, bit rs);
    for (int m = 0; m < 3; m++) begin
      if (r) pos[m] = h_tot(m) * v_tot(m) - 1;
      else if (c) pos[m] = (rs || pend) ? 0 : (pos[m] + 1) % (h_tot(m) * v_tot(m));
    end
    if (r || c) pend = 1'b0;
    else if (rs) pend = 1'b1;
  endtask

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cycle, observed, expected);
    end
  endtask

  task automatic applyStimulus(bit r, bit c, bit rs);
    rst = r;
    ce = c;
    restart = rs;
    @(posedge clk_pix);
    model_step(r, c, rs);
    #1;
    cycle++;
    checkOutput("dflt", pack(int'(d_sx), int'(d_sy), d_hs, d_vs, d_de, d_hb, d_vb, d_ln, d_fr),
                expect_vec(0, pos[0]));
    checkOutput("hd720", pack(int'(h_sx), int'(h_sy), h_hs, h_vs, h_de, h_hb, h_vb, h_ln, h_fr),
                expect_vec(1, pos[1]));
    checkOutput("tiny", pack(int'(t_sx), int'(t_sy), t_hs, t_vs, t_de, t_hb, t_vb, t_ln, t_fr),
                expect_vec(2, pos[2]));
  endtask

  task automatic run_to_x(int x);
    int n;
    n = 0;
    while ((pos[0] % h_tot(0)) != x && n < 2000) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      n++;
    end
  endtask

  initial begin
    rst = 1'b1;
    ce = 1'b0;
    restart = 1'b0;
    pend = 1'b0;
    vectors = 0;
    miscompares = 0;
    cycle = 0;
    for (int m = 0; m < 3; m++) pos[m] = 0;

    $display("[TB] reset, with ce and restart also high to show reset wins");
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);

    $display("[TB] free-running lines with ce tied high");
    repeat (2400) applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] ce toggling every other clock");
    for (int i = 0; i < 1700; i++) applyStimulus(1'b0, (i % 2) == 0, 1'b0);

    $display("[TB] restart with ce low, then ce");
    run_to_x(100);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] restart together with ce");
    run_to_x(300);
    applyStimulus(1'b0, 1'b1, 1'b1);

    $display("[TB] reset mid-line and recovery");
    run_to_x(400);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] randomized ce/restart/reset");
    for (int i = 0; i < 8000; i++) begin
      applyStimulus($urandom_range(0, 999) == 0, ($urandom % 4) != 0,
                    $urandom_range(0, 149) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
